// File: rtl/if_fetch.sv
// if_fetch - RV32I instruction-fetch stage over a byte-wide memory port.
//
// Fetches each instruction as four little-endian byte reads through the
// memory controller's request/grant handshake. It presents the assembled
// word, its PC and the predicted next PC (PC+4) to IF/ID. Redirects from
// execute override everything except reset. The memory-stage stall holds a
// presented instruction until decode takes it.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   mem_req     byte read request (registered)
//   mem_addr    byte address of the request, valid while mem_req=1
//   mem_gnt     controller accepts the request this cycle
//   mem_rdata   returned byte, valid with mem_rvalid
//   mem_rvalid  byte return, one cycle after each accepted request
//   br_e/br_pc  redirect from execute; br_pc bit 0 is forced to 0
//   stl_mm      memory-stage stall; a presented instruction is held
//   if_valid    if_inst/if_pc/if_ppc hold a complete instruction
//   if_inst     assembled instruction word
//   if_pc       address of if_inst
//   if_ppc      predicted next PC, if_pc+4
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rvalid,
   input  logic        br_e,
   input  logic [31:0] br_pc,
   input  logic        stl_mm,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_ppc
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [2:0]  req_cnt, req_cnt_n;   // bytes requested so far (0..4)
   logic [1:0]  rcv_idx, rcv_idx_n;   // index of the next byte to arrive
   logic [23:0] byte_buf, byte_buf_n;
   logic        outstanding, outstanding_n;
   logic        discard, discard_n;
   logic        mem_req_n;
   logic [31:0] mem_addr_n;
   logic        if_valid_n;
   logic [31:0] if_inst_n, if_pc_n, if_ppc_n;
   logic        accept, ret;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         req_cnt     <= '0;
         rcv_idx     <= '0;
         byte_buf    <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         if_valid    <= 1'b0;
         if_inst     <= '0;
         if_pc       <= '0;
         if_ppc      <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_cnt     <= req_cnt_n;
         rcv_idx     <= rcv_idx_n;
         byte_buf    <= byte_buf_n;
         outstanding <= outstanding_n;
         discard     <= discard_n;
         mem_req     <= mem_req_n;
         mem_addr    <= mem_addr_n;
         if_valid    <= if_valid_n;
         if_inst     <= if_inst_n;
         if_pc       <= if_pc_n;
         if_ppc      <= if_ppc_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      req_cnt_n     = req_cnt;
      rcv_idx_n     = rcv_idx;
      byte_buf_n    = byte_buf;
      discard_n     = discard;
      if_valid_n    = if_valid;
      if_inst_n     = if_inst;
      if_pc_n       = if_pc;
      if_ppc_n      = if_ppc;

      accept        = mem_req & mem_gnt;
      // Only a byte we are actually waiting for counts as a return.
      ret           = mem_rvalid & outstanding;
      outstanding_n = accept;

      if (br_e) begin
         pc_n       = {br_pc[31:1], 1'b0};
         req_cnt_n  = '0;
         rcv_idx_n  = '0;
         state_n    = FETCH;
         if_valid_n = 1'b0;
         // A byte accepted this cycle belongs to the old stream.
         discard_n  = accept;
      end else if (state == HOLD) begin
         if (!stl_mm) begin
            if_valid_n = 1'b0;
            pc_n       = pc + 32'd4;
            req_cnt_n  = '0;
            rcv_idx_n  = '0;
            state_n    = FETCH;
         end
      end else begin
         if (accept)
            req_cnt_n = req_cnt + 3'd1;
         if (ret) begin
            if (discard) begin
               discard_n = 1'b0;
            end else if (rcv_idx == 2'd3) begin
               if_inst_n  = {mem_rdata, byte_buf};
               if_pc_n    = pc;
               if_ppc_n   = pc + 32'd4;
               if_valid_n = 1'b1;
               state_n    = HOLD;
            end else begin
               case (rcv_idx)
                  2'd0:    byte_buf_n[7:0]   = mem_rdata;
                  2'd1:    byte_buf_n[15:8]  = mem_rdata;
                  default: byte_buf_n[23:16] = mem_rdata;
               endcase
               rcv_idx_n = rcv_idx + 2'd1;
            end
         end
      end

      // The request port is registered, so it is derived from next-cycle
      // state; a pending request simply repeats until granted.
      mem_req_n  = (state_n == FETCH) && !req_cnt_n[2];
      mem_addr_n = mem_req_n ? pc_n + {30'b0, req_cnt_n[1:0]} : mem_addr;
   end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, mem_req, mem_gnt, mem_rvalid, br_e, stl_mm, if_valid;
   logic [31:0] mem_addr, br_pc, if_inst, if_pc, if_ppc;
   logic [7:0]  mem_rdata;

   logic        rst2, req2, rv2, valid2;
   logic [31:0] addr2, inst2, pc2, ppc2;
   logic [7:0]  rd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .br_e(br_e), .br_pc(br_pc), .stl_mm(stl_mm), .if_valid(if_valid),
      .if_inst(if_inst), .if_pc(if_pc), .if_ppc(if_ppc));

   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst2), .mem_req(req2), .mem_addr(addr2),
      .mem_gnt(1'b1), .mem_rdata(rd2), .mem_rvalid(rv2),
      .br_e(1'b0), .br_pc(32'h0), .stl_mm(1'b0), .if_valid(valid2),
      .if_inst(inst2), .if_pc(pc2), .if_ppc(ppc2));

   // Memory image: bytes 13 05 00 00 at address 0, a hash elsewhere.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd0:   mem_byte = 8'h13;
         32'd1:   mem_byte = 8'h05;
         32'd2:   mem_byte = 8'h00;
         32'd3:   mem_byte = 8'h00;
         default: mem_byte = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      mem_word = {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
                  mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   // ---------------- reference model (transaction level) ----------------
   logic        m_on = 1'b0;
   logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_ppc;
   int          m_nreq;
   logic        m_due, m_drop, m_valid, m_req;
   logic [7:0]  got[$];

   always @(posedge clk) begin
      logic acc;
      if (rst) begin
         m_on = 1'b1; m_pc = 32'h0; m_nreq = 0; got.delete();
         m_due = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
         m_inst = 32'h0; m_ipc = 32'h0; m_ppc = 32'h0;
         m_req = 1'b0; m_addr = 32'h0;
      end else if (m_on) begin
         acc = m_req && mem_gnt;
         if (br_e) begin
            m_pc = br_pc & ~32'd1; m_nreq = 0; got.delete();
            m_valid = 1'b0; m_drop = acc;
         end else if (m_valid) begin
            if (!stl_mm) begin
               m_valid = 1'b0; m_pc = m_pc + 32'd4; m_nreq = 0; got.delete();
            end
         end else begin
            if (acc) m_nreq = m_nreq + 1;
            if (mem_rvalid && m_due) begin
               if (m_drop) m_drop = 1'b0;
               else got.push_back(mem_rdata);
               if (got.size() == 4) begin
                  m_inst  = {got[3], got[2], got[1], got[0]};
                  m_ipc   = m_pc;
                  m_ppc   = m_pc + 32'd4;
                  m_valid = 1'b1;
                  got.delete();
               end
            end
         end
         m_due = acc;
         m_req = !m_valid && (m_nreq < 4);
         if (m_req) m_addr = m_pc + 32'(m_nreq);
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         checks++;
         if (mem_req !== m_req || (m_req && mem_addr !== m_addr) ||
             if_valid !== m_valid || if_inst !== m_inst ||
             if_pc !== m_ipc || if_ppc !== m_ppc) begin
            errors++;
            $display("FAIL model t=%0t got req=%b addr=%h v=%b inst=%h pc=%h ppc=%h expected req=%b addr=%h v=%b inst=%h pc=%h ppc=%h",
                     $time, mem_req, mem_addr, if_valid, if_inst, if_pc, if_ppc,
                     m_req, m_addr, m_valid, m_inst, m_ipc, m_ppc);
         end
         if (if_valid === 1'b1) begin
            checks++;
            if (if_inst !== mem_word(if_pc)) begin
               errors++;
               $display("FAIL memword pc=%h got %h expected %h", if_pc, if_inst, mem_word(if_pc));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic        prev_acc = 1'b0, prev_acc2 = 1'b0, hold2 = 1'b1;
   logic [31:0] prev_addr = 32'h0, prev_addr2 = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs at a negedge, advance to the next negedge.
   task automatic cyc(input logic r, input logic g, input logic b,
                      input logic [31:0] bp, input logic s, input logic sp);
      rst        = r;
      rst2       = r && hold2;
      mem_rvalid = prev_acc || sp;
      mem_rdata  = prev_acc ? mem_byte(prev_addr) : 8'($urandom);
      mem_gnt    = g;
      br_e       = b;
      br_pc      = bp;
      stl_mm     = s;
      rv2        = prev_acc2;
      rd2        = prev_acc2 ? mem_byte(prev_addr2) : 8'h0;
      prev_acc   = mem_req && g;
      prev_addr  = mem_addr;
      prev_acc2  = req2;
      prev_addr2 = addr2;
      @(negedge clk);
   endtask

   // Two reset cycles then the idle cycle; returns at cycle 0.
   task automatic start(input logic check_reset);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      if (check_reset) begin
         chk("rst_req", 32'(mem_req), 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_valid", 32'(if_valid), 0);
         chk("rst_inst", if_inst, 0);
         chk("rst_ppc", if_ppc, 0);
      end
      cyc(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = 8'h0; br_e = 1'b0; br_pc = 32'h0; stl_mm = 1'b0;
      rv2 = 1'b0; rd2 = 8'h0;
      @(negedge clk);

      // best-case fetch, plus address wrap on the second instance
      start(1);
      for (int unsigned i = 0; i < 4; i++) begin
         chk("t1_req", 32'(mem_req), 1);
         chk("t1_addr", mem_addr, i);
         chk("wrap_addr", addr2, 32'hFFFF_FFFC + i);
         cyc(0, 1, 0, 0, 0, 0);
      end
      chk("t1_c4_valid", 32'(if_valid), 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("t1_valid", 32'(if_valid), 1);
      chk("t1_inst", if_inst, 32'h0000_0513);
      chk("t1_pc", if_pc, 0);
      chk("t1_ppc", if_ppc, 4);
      chk("wrap_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap_ppc", ppc2, 0);
      chk("wrap_inst", inst2, mem_word(32'hFFFF_FFFC));
      cyc(0, 1, 0, 0, 0, 0);
      chk("t1_next_addr", mem_addr, 4);
      chk("t1_next_req", 32'(mem_req), 1);
      chk("wrap_next_addr", addr2, 0);
      hold2 = 1'b0;

      // stall while holding
      start(0);
      for (int unsigned c = 0; c < 11; c++) begin
         if (c >= 5) begin
            chk("t2_hold_valid", 32'(if_valid), 1);
            chk("t2_hold_inst", if_inst, 32'h0000_0513);
            chk("t2_hold_req", 32'(mem_req), 0);
         end
         cyc(0, 1, 0, 0, (c >= 4 && c <= 9), 0);
      end
      chk("t2_valid_after", 32'(if_valid), 0);
      chk("t2_req_after", 32'(mem_req), 1);
      chk("t2_addr_after", mem_addr, 4);

      // grant withheld for 3 cycles after byte 1
      start(0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      for (int unsigned c = 2; c < 5; c++) begin
         chk("t3_addr_hold", mem_addr, 2);
         chk("t3_req_hold", 32'(mem_req), 1);
         cyc(0, 0, 0, 0, 0, 0);
      end
      chk("t3_addr_hold", mem_addr, 2);
      cyc(0, 1, 0, 0, 0, 0);
      chk("t3_addr3", mem_addr, 3);
      cyc(0, 1, 0, 0, 0, 0);
      chk("t3_c7_valid", 32'(if_valid), 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("t3_valid", 32'(if_valid), 1);
      chk("t3_inst", if_inst, 32'h0000_0513);

      // redirect in the cycle byte 2 is accepted
      start(0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h0000_1001, 0, 0);
      chk("t4_req", 32'(mem_req), 1);
      chk("t4_addr", mem_addr, 32'h0000_1000);
      for (int unsigned c = 3; c < 7; c++) cyc(0, 1, 0, 0, 0, 0);
      chk("t4_c7_valid", 32'(if_valid), 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("t4_valid", 32'(if_valid), 1);
      chk("t4_pc", if_pc, 32'h0000_1000);
      chk("t4_inst", if_inst, mem_word(32'h0000_1000));

      // redirect during a stalled hold
      start(0);
      for (int unsigned c = 0; c < 5; c++) cyc(0, 1, 0, 0, (c == 4), 0);
      chk("t5_valid_hold", 32'(if_valid), 1);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 1, 32'h0000_2000, 1, 0);
      chk("t5_valid_drop", 32'(if_valid), 0);
      chk("t5_addr", mem_addr, 32'h0000_2000);
      for (int unsigned c = 7; c < 11; c++) cyc(0, 1, 0, 0, 1, 0);
      chk("t5_c11_valid", 32'(if_valid), 0);
      cyc(0, 1, 0, 0, 1, 0);
      chk("t5_valid", 32'(if_valid), 1);
      chk("t5_pc", if_pc, 32'h0000_2000);
      chk("t5_inst", if_inst, mem_word(32'h0000_2000));

      // randomized traffic against the model
      for (int unsigned n = 0; n < 4000; n++) begin
         logic [31:0] bp;
         bp = $urandom;
         if ($urandom_range(0, 3) == 0) bp = 32'hFFFF_FFF0 | (bp & 32'hF);
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 29) == 0, bp, $urandom_range(0, 2) == 0,
             !prev_acc && ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
